// File: rtl/snes_pad_pkg.sv
// rtl/snes_pad_pkg.sv - shared state, button index and key code definitions for the SNES pad poller
package snes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam logic [7:0] KEY_NONE  = 8'd0;
    localparam logic [7:0] KEY_B     = 8'd1;
    localparam logic [7:0] KEY_Y     = 8'd2;
    localparam logic [7:0] KEY_UP    = 8'd5;
    localparam logic [7:0] KEY_DOWN  = 8'd6;
    localparam logic [7:0] KEY_LEFT  = 8'd7;
    localparam logic [7:0] KEY_RIGHT = 8'd8;
    localparam logic [7:0] KEY_A     = 8'd9;
    localparam logic [7:0] KEY_X     = 8'd10;

    // Buttons that may produce a key code; the code is simply bit index + 1.
    localparam logic [15:0] KEY_MASK = (16'd1 << BTN_B)    | (16'd1 << BTN_Y)    |
                                       (16'd1 << BTN_UP)   | (16'd1 << BTN_DOWN) |
                                       (16'd1 << BTN_LEFT) | (16'd1 << BTN_RIGHT) |
                                       (16'd1 << BTN_A)    | (16'd1 << BTN_X);

endpackage

// File: rtl/snes_key_priority.sv
// rtl/snes_key_priority.sv - combinational priority encoder from button word to key code
module snes_key_priority
    import snes_pad_pkg::*;
(
    input  logic [15:0] buttons_i,
    output logic [7:0]  code_o
);

    // Descending scan: the last hit written is the lowest-index pressed key.
    always_comb begin
        code_o = KEY_NONE;
        for (int i = 15; i >= 0; i--) begin
            if (KEY_MASK[i] && buttons_i[i]) begin
                code_o = 8'(i + 1);
            end
        end
    end

endmodule

// File: rtl/snes_pad_encoder.sv
// rtl/snes_pad_encoder.sv - SNES pad poller and key encoder; PAD_CHECK_EN adds pad_error
module snes_pad_encoder
    import snes_pad_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] buttons,
    output logic [7:0]  key_code,
`ifdef PAD_CHECK_EN
    output logic        pad_error,
`endif
    output logic        key_latch
);

    localparam int CYC_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam int POLL_W  = $clog2(POLL_CYCLES);

    localparam logic [CYC_W-1:0]  LATCH_LAST = CYC_W'(LATCH_CYCLES - 1);
    localparam logic [CYC_W-1:0]  HALF_LAST  = CYC_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

    logic              sync1_q;
    logic              sync2_q;
    logic [POLL_W-1:0] poll_q;
    logic [POLL_W-1:0] poll_d;
    logic              tick;
    logic              pend_q;
    state_t            state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [3:0]        idx_q;
    logic [15:0]       shift_q;
    logic              pad_latch_q;
    logic              pad_clk_q;
    logic [15:0]       buttons_q;
    logic [7:0]        key_code_q;
    logic              key_latch_q;
    logic [7:0]        frame_code;
    logic [7:0]        code_d;
`ifdef PAD_CHECK_EN
    logic              pad_error_q;
    logic              frame_err;
`endif

    snes_key_priority u_prio (
        .buttons_i (shift_q),
        .code_o    (frame_code)
    );

    assign tick   = (poll_q == POLL_LAST);
    assign poll_d = tick ? '0 : poll_q + POLL_W'(1);

    // A genuine pad reads its ID nibble as released; anything else means no usable pad.
`ifdef PAD_CHECK_EN
    assign frame_err = |shift_q[15:12];
    assign code_d    = frame_err ? KEY_NONE : frame_code;
`else
    assign code_d    = frame_code;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            poll_q      <= '0;
            pend_q      <= 1'b0;
            state_q     <= IDLE;
            cyc_q       <= '0;
            idx_q       <= 4'd0;
            shift_q     <= 16'h0000;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b1;
            buttons_q   <= 16'h0000;
            key_code_q  <= KEY_NONE;
            key_latch_q <= 1'b0;
`ifdef PAD_CHECK_EN
            pad_error_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= pad_data;
            sync2_q     <= sync1_q;
            poll_q      <= poll_d;
            key_latch_q <= 1'b0;
            if (tick) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    pad_clk_q   <= 1'b1;
                    pad_latch_q <= 1'b0;
                    // Serving the tick in the same cycle keeps frame starts exactly one poll period apart.
                    if (pend_q || tick) begin
                        pend_q      <= 1'b0;
                        pad_latch_q <= 1'b1;
                        cyc_q       <= '0;
                        state_q     <= LATCH;
                    end
                end
                LATCH: begin
                    if (cyc_q == LATCH_LAST) begin
                        pad_latch_q <= 1'b0;
                        pad_clk_q   <= 1'b0;
                        cyc_q       <= '0;
                        idx_q       <= 4'd0;
                        state_q     <= LOW;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                LOW: begin
                    if (cyc_q == HALF_LAST) begin
                        shift_q[idx_q] <= ~sync2_q;
                        pad_clk_q      <= 1'b1;
                        cyc_q          <= '0;
                        state_q        <= HIGH;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                HIGH: begin
                    if (cyc_q == HALF_LAST) begin
                        cyc_q <= '0;
                        if (idx_q == 4'd15) begin
                            state_q <= DONE;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            pad_clk_q <= 1'b0;
                            state_q   <= LOW;
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                DONE: begin
                    buttons_q   <= shift_q;
                    key_code_q  <= code_d;
                    key_latch_q <= 1'b1;
`ifdef PAD_CHECK_EN
                    pad_error_q <= frame_err;
`endif
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign buttons   = buttons_q;
    assign key_code  = key_code_q;
    assign key_latch = key_latch_q;
`ifdef PAD_CHECK_EN
    assign pad_error = pad_error_q;
`endif

endmodule

// File: tb/tb_snes_pad_encoder.sv
// tb/tb_snes_pad_encoder.sv - self-checking bench for snes_pad_encoder with a behavioural pad and timing model
module tb_snes_pad_encoder;

    localparam int LATCH = 4;
    localparam int HALF  = 3;
    localparam int POLL  = 200;

    logic        clk;
    logic        rst_n;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [15:0] buttons;
    logic [7:0]  key_code;
    logic        key_latch;
`ifdef PAD_CHECK_EN
    logic        pad_error;
`endif

    int total = 0;
    int bad   = 0;

    snes_pad_encoder #(
        .LATCH_CYCLES (LATCH),
        .HALF_CYCLES  (HALF),
        .POLL_CYCLES  (POLL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons   (buttons),
        .key_code  (key_code),
`ifdef PAD_CHECK_EN
        .pad_error (pad_error),
`endif
        .key_latch (key_latch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: bit 0 presented while latched, next bit after each rising pad_clk.
    logic [15:0] pad_word;
    int          bitpos = 16;
    logic        ovr;
    logic        ovr_val;
    logic        model_bit;

    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) bitpos <= 0;
        else if (bitpos < 16) bitpos <= bitpos + 1;
    end
    assign model_bit = (bitpos < 16) ? ~pad_word[bitpos] : 1'b0;
    assign pad_data  = ovr ? ovr_val : model_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_code(input logic [15:0] w);
        int order[8] = '{0, 1, 4, 5, 6, 7, 8, 9};
`ifdef PAD_CHECK_EN
        if (w[15:12] != 4'h0) return 8'h00;
`endif
        for (int k = 0; k < 8; k++) begin
            if (w[order[k]]) return 8'(order[k] + 1);
        end
        return 8'h00;
    endfunction

    // Per-cycle compare process sampling on the falling edge.
    int   cyc_rel, lat_len, low_len, high_len, rises, last_start, strobes;
    bit   have_start;
    logic prev_latch, prev_clk, prev_kl;
    logic [7:0] prev_code;

    initial strobes = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_pad_latch", pad_latch, 1'b0);
            check("rst_pad_clk", pad_clk, 1'b1);
            check("rst_buttons", buttons, 16'h0000);
            check("rst_key_code", key_code, 8'h00);
            check("rst_key_latch", key_latch, 1'b0);
`ifdef PAD_CHECK_EN
            check("rst_pad_error", pad_error, 1'b0);
`endif
            cyc_rel = 0; lat_len = 0; low_len = 0; high_len = 0; rises = 0;
            have_start = 0; prev_latch = 1'b0; prev_clk = 1'b1; prev_kl = 1'b0; prev_code = 8'h00;
        end else begin
            cyc_rel++;
            if (pad_latch && !prev_latch) begin
                if (have_start) check("frame_period", cyc_rel - last_start, POLL);
                else            check("first_latch_delay", cyc_rel, POLL);
                last_start = cyc_rel;
                have_start = 1;
                rises      = 0;
                lat_len    = 0;
            end
            if (pad_latch) begin
                lat_len++;
                check("latch_clk_high", pad_clk, 1'b1);
            end
            if (!pad_latch && prev_latch) check("latch_len", lat_len, LATCH);
            if (!pad_clk) begin
                if (prev_clk) begin
                    if (!prev_latch) check("high_len", high_len, HALF);
                    low_len = 1;
                end else begin
                    low_len++;
                end
            end else begin
                if (!prev_clk) begin
                    check("low_len", low_len, HALF);
                    rises++;
                    high_len = 1;
                end else begin
                    high_len++;
                end
            end
            if (key_latch) begin
                check("strobe_after_prev_low", prev_kl, 1'b0);
                check("strobe_rises", rises, 16);
                check("strobe_buttons", buttons, pad_word);
                check("strobe_key_code", key_code, model_code(pad_word));
`ifdef PAD_CHECK_EN
                check("strobe_pad_error", pad_error, (pad_word[15:12] != 4'h0));
`endif
                strobes++;
            end else begin
                check("code_hold", key_code, prev_code);
            end
            if (prev_kl) check("strobe_width", key_latch, 1'b0);
            prev_latch = pad_latch;
            prev_clk   = pad_clk;
            prev_kl    = key_latch;
            prev_code  = key_code;
        end
    end

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_latch && n < 400);
        if (!key_latch) begin
            total++;
            bad++;
            $display("FAIL strobe_timeout: got no key_latch expected one within 400 cycles");
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [7:0]  code;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'h0201, 8'h01}, '{16'h0008, 8'h00}, '{16'h00F0, 8'h05},
        '{16'h0C0C, 8'h00}, '{16'h0040, 8'h07}, '{16'h0002, 8'h02},
        '{16'h0200, 8'h0A}, '{16'h0080, 8'h08}, '{16'h0020, 8'h06}
    };

    initial begin
        int n;
        int s0;
        rst_n    = 1'b0;
        ovr      = 1'b1;
        ovr_val  = 1'b0;
        pad_word = 16'h0100;
        repeat (8) begin
            @(negedge clk);
            ovr_val = ~ovr_val;
        end
        ovr = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        wait_strobe();
        check("a_buttons", buttons, 16'h0100);
        check("a_key_code", key_code, 8'h09);
        @(negedge clk);
        check("a_strobe_one_cycle", key_latch, 1'b0);

        foreach (vecs[i]) begin
            pad_word = vecs[i].word;
            wait_strobe();
            check("vec_buttons", buttons, vecs[i].word);
            check("vec_key_code", key_code, vecs[i].code);
            @(negedge clk);
        end

        pad_word = 16'hF100;
        wait_strobe();
        check("id_buttons", buttons, 16'hF100);
`ifndef PAD_CHECK_EN
        check("id_ignored_code", key_code, 8'h09);
`endif
        @(negedge clk);

        // Reset while bit 7 is being clocked out.
        pad_word = 16'h0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pad_latch == 1'b0 && pad_clk == 1'b0 && rises == 7) && n < 400);
        check("reached_bit7", rises, 7);
        s0 = strobes;
        #3 rst_n = 1'b0;
        #1;
        check("async_pad_latch", pad_latch, 1'b0);
        check("async_pad_clk", pad_clk, 1'b1);
        check("async_buttons", buttons, 16'h0000);
        check("async_key_code", key_code, 8'h00);
        check("async_key_latch", key_latch, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pad_latch && n < 400);
        check("restart_delay", n, POLL);
        check("no_partial_strobe", strobes, s0);
        wait_strobe();
        check("restart_buttons", buttons, 16'h0001);
        check("restart_key_code", key_code, 8'h01);
        @(negedge clk);

`ifdef PAD_CHECK_EN
        pad_word = 16'hFFFF;
        wait_strobe();
        check("absent_pad_error", pad_error, 1'b1);
        check("absent_key_code", key_code, 8'h00);
        check("absent_buttons", buttons, 16'hFFFF);
        @(negedge clk);
        pad_word = 16'h0010;
        wait_strobe();
        check("up_pad_error", pad_error, 1'b0);
        check("up_key_code", key_code, 8'h05);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
